// File: rtl/serial_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_fifo_ctrl_if
// Brief    : Device-bus and UART-side signal bundle for serial_fifo_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  enable_i;
    logic                  readEnable_i;
    logic [1:0]            regSel_i;
    logic [31:0]           dataSave_i;
    logic [31:0]           dataLoad_o;
    logic                  int_o;
    logic                  rxdReady_i;
    logic [DATA_WIDTH-1:0] rxdData_i;
    logic                  txdBusy_i;
    logic                  txdStart_o;
    logic [DATA_WIDTH-1:0] txdData_o;

    modport master (
        output enable_i, readEnable_i, regSel_i, dataSave_i,
        output rxdReady_i, rxdData_i, txdBusy_i,
        input  dataLoad_o, int_o, txdStart_o, txdData_o
    );

    modport slave (
        input  enable_i, readEnable_i, regSel_i, dataSave_i,
        input  rxdReady_i, rxdData_i, txdBusy_i,
        output dataLoad_o, int_o, txdStart_o, txdData_o
    );
endinterface
`default_nettype wire

// File: rtl/serial_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_fifo_ctrl
// Brief    : COM controller with RX/TX FIFOs, status/ctrl/count registers and
//            a maskable interrupt. Define SERIAL_TX_INT_EN for the TX-drained IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module serial_fifo_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter bit RX_IE_RESET   = 1'b1
) (
    input  logic              clkMain,
    input  logic              rst,
    serial_fifo_ctrl_if.slave bus
);
    typedef logic [RX_DEPTH_LOG2-1:0] rx_ptr_t;
    typedef logic [RX_DEPTH_LOG2:0]   rx_cnt_t;
    typedef logic [TX_DEPTH_LOG2-1:0] tx_ptr_t;
    typedef logic [TX_DEPTH_LOG2:0]   tx_cnt_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_GUARD = 2'd2,
        S_WAIT  = 2'd3
    } tx_state_t;

    logic [DATA_WIDTH-1:0] r_rxMem [1<<RX_DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] r_txMem [1<<TX_DEPTH_LOG2];
    rx_ptr_t               r_rxWr, r_rxRd;
    rx_cnt_t               r_rxCount;
    tx_ptr_t               r_txWr, r_txRd;
    tx_cnt_t               r_txCount;
    logic                  r_rxOvf, r_txOvf, r_rxIntEn;
    tx_state_t             r_state;
    logic                  r_txdStart;
    logic [DATA_WIDTH-1:0] r_txdData;
    logic                  r_int;

    logic        w_rdAcc, w_wrAcc, w_dataRd, w_dataWr, w_ctrlWr;
    logic        w_rxEmpty, w_rxFull, w_rxPop, w_rxPush, w_rxDrop;
    logic        w_txEmpty, w_txFull, w_txPop, w_txPush, w_txDrop;
    logic        w_txIdle, w_txIntEn, w_txTerm;
    logic [31:0] w_dataLoad;
    logic        w_unused;

    assign w_rdAcc  = bus.enable_i & bus.readEnable_i;
    assign w_wrAcc  = bus.enable_i & ~bus.readEnable_i;
    assign w_dataRd = w_rdAcc & (bus.regSel_i == 2'd0);
    assign w_dataWr = w_wrAcc & (bus.regSel_i == 2'd0);
    assign w_ctrlWr = w_wrAcc & (bus.regSel_i == 2'd2);

    // Count never exceeds depth, so its MSB alone marks "full".
    assign w_rxEmpty = (r_rxCount == '0);
    assign w_rxFull  = r_rxCount[RX_DEPTH_LOG2];
    assign w_rxPop   = w_dataRd & ~w_rxEmpty;
    assign w_rxPush  = bus.rxdReady_i & (~w_rxFull | w_rxPop);
    assign w_rxDrop  = bus.rxdReady_i & ~w_rxPush;

    assign w_txEmpty = (r_txCount == '0);
    assign w_txFull  = r_txCount[TX_DEPTH_LOG2];
    assign w_txIdle  = (r_state == S_IDLE);
    assign w_txPop   = w_txIdle & ~w_txEmpty & ~bus.txdBusy_i;
    assign w_txPush  = w_dataWr & (~w_txFull | w_txPop);
    assign w_txDrop  = w_dataWr & ~w_txPush;

    assign w_unused  = ^bus.dataSave_i;

`ifdef SERIAL_TX_INT_EN
    logic r_txIntEn;
    always_ff @(posedge clkMain) begin
        if (rst) begin
            r_txIntEn <= 1'b0;
        end else if (w_ctrlWr) begin
            r_txIntEn <= bus.dataSave_i[1];
        end
    end
    assign w_txIntEn = r_txIntEn;
`else
    assign w_txIntEn = 1'b0;
`endif

    assign w_txTerm = w_txIntEn & w_txEmpty & w_txIdle;

    always_ff @(posedge clkMain) begin
        if (rst) begin
            r_rxWr    <= '0;
            r_rxRd    <= '0;
            r_rxCount <= '0;
        end else begin
            if (w_rxPush) r_rxWr <= r_rxWr + rx_ptr_t'(1);
            if (w_rxPop)  r_rxRd <= r_rxRd + rx_ptr_t'(1);
            case ({w_rxPush, w_rxPop})
                2'b10:   r_rxCount <= r_rxCount + rx_cnt_t'(1);
                2'b01:   r_rxCount <= r_rxCount - rx_cnt_t'(1);
                default: r_rxCount <= r_rxCount;
            endcase
        end
    end

    always_ff @(posedge clkMain) begin
        if (w_rxPush) r_rxMem[r_rxWr] <= bus.rxdData_i;
    end

    always_ff @(posedge clkMain) begin
        if (rst) begin
            r_txWr    <= '0;
            r_txRd    <= '0;
            r_txCount <= '0;
        end else begin
            if (w_txPush) r_txWr <= r_txWr + tx_ptr_t'(1);
            if (w_txPop)  r_txRd <= r_txRd + tx_ptr_t'(1);
            case ({w_txPush, w_txPop})
                2'b10:   r_txCount <= r_txCount + tx_cnt_t'(1);
                2'b01:   r_txCount <= r_txCount - tx_cnt_t'(1);
                default: r_txCount <= r_txCount;
            endcase
        end
    end

    always_ff @(posedge clkMain) begin
        if (w_txPush) r_txMem[r_txWr] <= bus.dataSave_i[DATA_WIDTH-1:0];
    end

    // A fresh overflow in the same cycle as a clear request wins, so no drop goes unreported.
    always_ff @(posedge clkMain) begin
        if (rst) begin
            r_rxIntEn <= RX_IE_RESET;
            r_rxOvf   <= 1'b0;
            r_txOvf   <= 1'b0;
        end else begin
            if (w_ctrlWr) begin
                r_rxIntEn <= bus.dataSave_i[0];
                if (bus.dataSave_i[2]) begin
                    r_rxOvf <= 1'b0;
                    r_txOvf <= 1'b0;
                end
            end
            if (w_rxDrop) r_rxOvf <= 1'b1;
            if (w_txDrop) r_txOvf <= 1'b1;
        end
    end

    always_ff @(posedge clkMain) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_txdStart <= 1'b0;
            r_txdData  <= '0;
            r_int      <= 1'b0;
        end else begin
            r_txdStart <= 1'b0;
            r_int      <= (r_rxIntEn & ~w_rxEmpty) | w_txTerm;
            case (r_state)
                S_IDLE: begin
                    if (w_txPop) begin
                        r_txdData  <= r_txMem[r_txRd];
                        r_txdStart <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: r_state <= S_GUARD;
                // GUARD gives the transmitter one cycle to raise busy before it is sampled.
                S_GUARD: r_state <= S_WAIT;
                S_WAIT:  if (!bus.txdBusy_i) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_dataLoad = '0;
        if (w_rdAcc) begin
            case (bus.regSel_i)
                2'd0:    if (!w_rxEmpty) w_dataLoad = 32'(r_rxMem[r_rxRd]);
                2'd1:    w_dataLoad = {26'b0, r_txOvf, r_rxOvf, w_txFull,
                                       w_txEmpty & w_txIdle, w_rxFull, ~w_rxEmpty};
                2'd2:    w_dataLoad = {30'b0, w_txIntEn, r_rxIntEn};
                default: w_dataLoad = {16'b0, 8'(r_txCount), 8'(r_rxCount)};
            endcase
        end
    end

    assign bus.dataLoad_o = w_dataLoad;
    assign bus.int_o      = r_int;
    assign bus.txdStart_o = r_txdStart;
    assign bus.txdData_o  = r_txdData;
endmodule
`default_nettype wire
